// File: rtl/sprite_anim_if.sv
// Bundle between the sprite position/raster logic and one sprite animator.
// Master drives raster, position and pose controls; slave returns ROM address and status.
interface sprite_anim_if #(
    parameter int ADDR_W = 21,
    parameter int FIDX_W = 2
);
    logic              anim_tick;
    logic              enable;
    logic              moving;
    logic              facing_left;
    logic [1:0]        mode;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        SpriteX;
    logic [9:0]        SpriteY;
    logic              sprite_on;
    logic [ADDR_W-1:0] sprite_addr;
    logic [FIDX_W-1:0] frame_idx;
    logic              anim_done;

    modport master (
        output anim_tick, enable, moving, facing_left, mode,
        output DrawX, DrawY, SpriteX, SpriteY,
        input  sprite_on, sprite_addr, frame_idx, anim_done
    );

    modport slave (
        input  anim_tick, enable, moving, facing_left, mode,
        input  DrawX, DrawY, SpriteX, SpriteY,
        output sprite_on, sprite_addr, frame_idx, anim_done
    );
endinterface

// File: rtl/sprite_anim_engine.sv
// Parametrised sprite animator: raster window detect, sprite ROM address
// generation and a tick-driven frame sequencer (loop/ping-pong/one-shot/static).
module sprite_anim_engine #(
    parameter int SPR_W       = 46,
    parameter int SPR_H       = 70,
    parameter int N_FRAMES    = 4,
    parameter int HOLD        = 4,
    parameter int BASE_ADDR   = 33064,
    parameter int LEFT_OFFSET = 50620,
    parameter int ADDR_W      = 21
) (
    input  logic          frame_Clk,
    input  logic          Reset,
    sprite_anim_if.slave  bus
);
    localparam int FIDX_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [FIDX_W-1:0] LAST     = FIDX_W'(N_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD - 1);
    localparam logic [31:0]       FRAME_SZ = 32'(SPR_W * SPR_H);

    typedef enum logic [1:0] {
        LOOP     = 2'd0,
        PINGPONG = 2'd1,
        ONESHOT  = 2'd2,
        STATIC   = 2'd3
    } mode_t;

    logic [FIDX_W-1:0] frameIdx;
    logic [HOLD_W-1:0] holdCnt;
    logic              dirDown;
    logic              animDone;
    mode_t             prevMode;
    logic [ADDR_W-1:0] spriteAddr;

    logic              restart;
    logic              onBox;
    logic [10:0]       relX;
    logic [10:0]       relY;
    logic [10:0]       drawX11;
    logic [10:0]       drawY11;
    logic [10:0]       sprX11;
    logic [10:0]       sprY11;
    logic [ADDR_W-1:0] addrSum;
    logic [FIDX_W-1:0] frameUp;
    logic [FIDX_W-1:0] frameDn;

    // Widen to 11 bits so a box near the right/bottom edge never wraps.
    assign drawX11 = {1'b0, bus.DrawX};
    assign drawY11 = {1'b0, bus.DrawY};
    assign sprX11  = {1'b0, bus.SpriteX};
    assign sprY11  = {1'b0, bus.SpriteY};

    assign onBox = (drawX11 >= sprX11)
                && (drawX11 <= sprX11 + 11'(SPR_W - 1))
                && (drawY11 >= sprY11)
                && (drawY11 <= sprY11 + 11'(SPR_H - 1));

    assign relX = drawX11 - sprX11;
    assign relY = drawY11 - sprY11;

    assign addrSum = ADDR_W'(32'(BASE_ADDR)
                   + (bus.facing_left ? 32'(LEFT_OFFSET) : 32'd0)
                   + 32'(frameIdx) * FRAME_SZ
                   + 32'(relY) * 32'(SPR_W)
                   + 32'(relX));

    assign restart = !bus.enable || !bus.moving || (bus.mode != prevMode);

    assign frameUp = (frameIdx == LAST) ? '0 : frameIdx + FIDX_W'(1);
    assign frameDn = (frameIdx == '0) ? '0 : frameIdx - FIDX_W'(1);

    // Frame sequencer: restart on idle or mode change, otherwise step on held ticks.
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            frameIdx <= '0;
            holdCnt  <= '0;
            dirDown  <= 1'b0;
            animDone <= 1'b0;
            prevMode <= mode_t'(bus.mode);
        end else begin
            prevMode <= mode_t'(bus.mode);
            if (restart) begin
                frameIdx <= '0;
                holdCnt  <= '0;
                dirDown  <= 1'b0;
                animDone <= 1'b0;
            end else if (bus.anim_tick) begin
                if (holdCnt != HOLD_MAX) begin
                    holdCnt <= holdCnt + HOLD_W'(1);
                end else begin
                    holdCnt <= '0;
                    unique case (prevMode)
                        LOOP: begin
                            frameIdx <= frameUp;
                        end
                        PINGPONG: begin
                            if (!dirDown) begin
                                if (frameIdx != LAST) begin
                                    frameIdx <= frameUp;
                                    dirDown  <= (frameUp == LAST);
                                end
                            end else begin
                                frameIdx <= frameDn;
                                dirDown  <= (frameDn != '0);
                            end
                        end
                        ONESHOT: begin
                            if (frameIdx != LAST) begin
                                frameIdx <= frameUp;
                                animDone <= (frameUp == LAST);
                            end else begin
                                animDone <= 1'b1;
                            end
                        end
                        STATIC: begin
                            frameIdx <= '0;
                            animDone <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // ROM address pipeline: one cycle behind the raster, zero outside the box.
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            spriteAddr <= '0;
        end else begin
            spriteAddr <= onBox ? addrSum : '0;
        end
    end

    assign bus.sprite_on   = onBox;
    assign bus.sprite_addr = spriteAddr;
    assign bus.frame_idx   = frameIdx;
    assign bus.anim_done   = animDone;
endmodule

// File: tb/tb_sprite_anim_engine.sv
// Bench for sprite_anim_engine: three parameter sets driven in lock-step,
// checked every cycle against a tick-count model plus hand-computed values.
module tb_sprite_anim_engine;
    logic       frame_Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       animTick = 1'b0;
    logic       enable = 1'b0;
    logic       moving = 1'b0;
    logic       facingLeft = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] drawX = 10'd0;
    logic [9:0] drawY = 10'd0;
    logic [9:0] spriteX = 10'd0;
    logic [9:0] spriteY = 10'd0;

    int checks = 0;
    int errors = 0;

    always #5 frame_Clk = ~frame_Clk;

    sprite_anim_if #(.ADDR_W(21), .FIDX_W(2)) ifA ();
    sprite_anim_if #(.ADDR_W(21), .FIDX_W(2)) ifB ();
    sprite_anim_if #(.ADDR_W(21), .FIDX_W(1)) ifC ();

    assign ifA.anim_tick = animTick;   assign ifB.anim_tick = animTick;   assign ifC.anim_tick = animTick;
    assign ifA.enable = enable;        assign ifB.enable = enable;        assign ifC.enable = enable;
    assign ifA.moving = moving;        assign ifB.moving = moving;        assign ifC.moving = moving;
    assign ifA.facing_left = facingLeft; assign ifB.facing_left = facingLeft; assign ifC.facing_left = facingLeft;
    assign ifA.mode = mode;            assign ifB.mode = mode;            assign ifC.mode = mode;
    assign ifA.DrawX = drawX;          assign ifB.DrawX = drawX;          assign ifC.DrawX = drawX;
    assign ifA.DrawY = drawY;          assign ifB.DrawY = drawY;          assign ifC.DrawY = drawY;
    assign ifA.SpriteX = spriteX;      assign ifB.SpriteX = spriteX;      assign ifC.SpriteX = spriteX;
    assign ifA.SpriteY = spriteY;      assign ifB.SpriteY = spriteY;      assign ifC.SpriteY = spriteY;

    sprite_anim_engine dutA (.frame_Clk(frame_Clk), .Reset(Reset), .bus(ifA));
    sprite_anim_engine #(.HOLD(1)) dutB (.frame_Clk(frame_Clk), .Reset(Reset), .bus(ifB));
    sprite_anim_engine #(.N_FRAMES(2), .HOLD(2)) dutC (.frame_Clk(frame_Clk), .Reset(Reset), .bus(ifC));

    // Model: everything follows from the count of accepted ticks since the last restart.
    int         nf [3] = '{4, 4, 2};
    int         hd [3] = '{4, 1, 2};
    int         ticks = 0;
    logic [1:0] pm = 2'd0;
    logic       modelUp = 1'b0;
    int         expAddr [3] = '{0, 0, 0};

    function automatic int mFrame(int k);
        int n = nf[k];
        int s = ticks / hd[k];
        int per;
        case (pm)
            2'd0: return s % n;
            2'd1: begin
                if (n == 1) return 0;
                per = 2 * (n - 1);
                s = s % per;
                return (s < n) ? s : per - s;
            end
            2'd2: return (s < n - 1) ? s : n - 1;
            default: return 0;
        endcase
    endfunction

    function automatic int mDone(int k);
        int n = nf[k];
        int s = ticks / hd[k];
        int need = (n - 1 > 1) ? n - 1 : 1;
        return (pm == 2'd2 && s >= need) ? 1 : 0;
    endfunction

    function automatic int mOn();
        int dx = int'(drawX) - int'(spriteX);
        int dy = int'(drawY) - int'(spriteY);
        return (dx >= 0 && dx < 46 && dy >= 0 && dy < 70) ? 1 : 0;
    endfunction

    function automatic int mAddr(int k);
        int dx = int'(drawX) - int'(spriteX);
        int dy = int'(drawY) - int'(spriteY);
        int a;
        if (mOn() == 0) return 0;
        a = 33064 + (facingLeft ? 50620 : 0) + mFrame(k) * 3220 + dy * 46 + dx;
        return a % (1 << 21);
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model on each edge using the inputs the DUT sees.
    always @(posedge frame_Clk) begin
        for (int k = 0; k < 3; k++) expAddr[k] = Reset ? 0 : mAddr(k);
        if (Reset) begin
            ticks = 0;
            pm = mode;
            modelUp = 1'b1;
        end else if (!enable || !moving || mode != pm) begin
            ticks = 0;
            pm = mode;
        end else if (animTick) begin
            ticks++;
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge frame_Clk) begin
        if (modelUp) begin
            cmp("A.frame", int'(ifA.frame_idx), mFrame(0));
            cmp("A.done", int'(ifA.anim_done), mDone(0));
            cmp("A.on", int'(ifA.sprite_on), mOn());
            cmp("A.addr", int'(ifA.sprite_addr), expAddr[0]);
            cmp("B.frame", int'(ifB.frame_idx), mFrame(1));
            cmp("B.done", int'(ifB.anim_done), mDone(1));
            cmp("B.on", int'(ifB.sprite_on), mOn());
            cmp("B.addr", int'(ifB.sprite_addr), expAddr[1]);
            cmp("C.frame", int'(ifC.frame_idx), mFrame(2));
            cmp("C.done", int'(ifC.anim_done), mDone(2));
            cmp("C.on", int'(ifC.sprite_on), mOn());
            cmp("C.addr", int'(ifC.sprite_addr), expAddr[2]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge frame_Clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            animTick = 1'b1;
            step(1);
            animTick = 1'b0;
            step(1);
        end
    endtask

    int pp [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int sx [4] = '{99, 100, 145, 146};
    int sy [4] = '{49, 50, 119, 120};

    initial begin
        step(2);
        cmp("lit.reset.frame", int'(ifA.frame_idx), 0);
        cmp("lit.reset.done", int'(ifA.anim_done), 0);
        cmp("lit.reset.addr", int'(ifA.sprite_addr), 0);

        Reset = 1'b0;
        enable = 1'b1;
        moving = 1'b1;
        mode = 2'd0;
        step(1);
        tick(4);  cmp("lit.loop4", int'(ifA.frame_idx), 1);
        tick(4);  cmp("lit.loop8", int'(ifA.frame_idx), 2);
        tick(4);  cmp("lit.loop12", int'(ifA.frame_idx), 3);
        tick(4);  cmp("lit.loop16", int'(ifA.frame_idx), 0);
        tick(1);  cmp("lit.loop17", int'(ifA.frame_idx), 0);
        cmp("lit.loopB17", int'(ifB.frame_idx), 1);

        tick(5);  cmp("lit.loop22", int'(ifA.frame_idx), 1);
        mode = 2'd1;
        animTick = 1'b1;
        step(1);
        animTick = 1'b0;
        cmp("lit.modechg", int'(ifA.frame_idx), 0);
        step(1);
        tick(3);  cmp("lit.holdclr3", int'(ifA.frame_idx), 0);
        tick(1);  cmp("lit.holdclr4", int'(ifA.frame_idx), 1);

        moving = 1'b0;
        step(1);
        moving = 1'b1;
        step(1);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            cmp("lit.pingpong", int'(ifB.frame_idx), pp[i]);
        end
        cmp("lit.pingpongC", int'(ifC.frame_idx), 0);

        mode = 2'd2;
        step(1);
        tick(3);
        cmp("lit.oneshot.frame", int'(ifB.frame_idx), 3);
        cmp("lit.oneshot.done", int'(ifB.anim_done), 1);
        tick(5);
        cmp("lit.oneshot.hold", int'(ifB.frame_idx), 3);
        cmp("lit.oneshot.holddone", int'(ifB.anim_done), 1);
        cmp("lit.oneshotC.done", int'(ifC.anim_done), 1);
        moving = 1'b0;
        step(1);
        cmp("lit.oneshot.idle", int'(ifB.frame_idx), 0);
        cmp("lit.oneshot.idledone", int'(ifB.anim_done), 0);
        moving = 1'b1;
        step(1);

        mode = 2'd3;
        step(1);
        tick(6);
        cmp("lit.static", int'(ifB.frame_idx), 0);

        mode = 2'd0;
        step(1);
        tick(2);
        spriteX = 10'd100;
        spriteY = 10'd50;
        drawX = 10'd101;
        drawY = 10'd52;
        facingLeft = 1'b0;
        #1 cmp("lit.on", int'(ifB.sprite_on), 1);
        step(1);
        cmp("lit.addrR", int'(ifB.sprite_addr), 39597);
        facingLeft = 1'b1;
        step(1);
        cmp("lit.addrL", int'(ifB.sprite_addr), 90217);
        drawX = 10'd146;
        #1 cmp("lit.offR", int'(ifB.sprite_on), 0);
        step(1);
        cmp("lit.addrOff", int'(ifB.sprite_addr), 0);
        facingLeft = 1'b0;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                drawX = 10'(sx[i]);
                drawY = 10'(sy[j]);
                step(1);
            end
        end

        spriteX = 10'd1000;
        drawX = 10'd1023;
        drawY = 10'd52;
        #1 cmp("lit.edgeOn", int'(ifA.sprite_on), 1);
        step(1);
        drawX = 10'd5;
        #1 cmp("lit.noWrapX", int'(ifA.sprite_on), 0);
        step(1);
        spriteX = 10'd0;
        spriteY = 10'd990;
        drawY = 10'd5;
        #1 cmp("lit.noWrapY", int'(ifA.sprite_on), 0);
        step(1);
        spriteY = 10'd0;
        drawY = 10'd10;

        tick(5);
        cmp("lit.preRstA", int'(ifA.frame_idx), 1);
        Reset = 1'b1;
        animTick = 1'b1;
        step(1);
        Reset = 1'b0;
        animTick = 1'b0;
        cmp("lit.rstTickA", int'(ifA.frame_idx), 0);
        cmp("lit.rstTickB", int'(ifB.frame_idx), 0);
        cmp("lit.rstAddr", int'(ifA.sprite_addr), 0);
        step(1);
        tick(4);
        cmp("lit.postRst", int'(ifA.frame_idx), 1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
